// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, reset PC and fetch FSM encoding
package cpu_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - one-entry instruction/pc holding register
module fetch_buffer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              capture,
    input  logic [DATA_W-1:0] cap_data,
    input  logic [ADDR_W-1:0] cap_pc,
    input  logic              consume,
    input  logic              flush,
    output logic              buf_valid,
    output logic [DATA_W-1:0] buf_data,
    output logic [ADDR_W-1:0] buf_pc
);

    // Flush beats capture beats consume; capture+consume keeps the new word valid
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
            buf_pc    <= '0;
        end else if (flush) begin
            buf_valid <= 1'b0;
        end else if (capture) begin
            buf_valid <= 1'b1;
            buf_data  <= cap_data;
            buf_pc    <= cap_pc;
        end else if (consume) begin
            buf_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, single-outstanding fetch FSM and IR load
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              ir_ready,
    output logic              ir_load,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              buf_valid;
    logic              capture;
    logic              can_issue;
    logic              granted;

    assign ir_load   = buf_valid & ir_ready & ~redirect_valid;
    assign can_issue = run & (~buf_valid | ir_load) & ~redirect_valid;
    assign mem_addr  = pc;
    assign granted   = mem_req & mem_gnt;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, request and buffer-capture decode; redirect overrides everything
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (run && !redirect_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_req = can_issue;
                if (mem_req && mem_gnt) begin
                    state_nxt = WAIT;
                end else if (!run && !redirect_valid) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    // A response arriving with the redirect is stale and closes the fetch
                    state_nxt = mem_rvalid ? ISSUE : DRAIN;
                end else if (mem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            DRAIN: begin
                // The squashed response still has to come back before a new request
                if (mem_rvalid) begin
                    state_nxt = ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Program counter and address of the in-flight request
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc     <= RESET_PC;
            req_pc <= '0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (granted) begin
            req_pc <= pc;
            pc     <= pc + 1'b1;
        end
    end

    fetch_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fetch_buffer (
        .clk       (clk),
        .resetn    (resetn),
        .capture   (capture),
        .cap_data  (mem_rdata),
        .cap_pc    (req_pc),
        .consume   (ir_load),
        .flush     (redirect_valid),
        .buf_valid (buf_valid),
        .buf_data  (instr_out),
        .buf_pc    (instr_pc)
    );

endmodule
